// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan controller: FSM state encoding,
// active-low segment glyph table and the "everything dark" constants.
package fnd_pkg;

    // Scan FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // Dark values for the active-low segment and anode buses
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} glyphs indexed by nibble value.
    // Listed from entry 15 (F) down to entry 0 because packed arrays
    // fill from the most significant element.
    localparam logic [15:0][6:0] GLYPH_TBL = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // Active-low anode pattern with only digit 'sel' driven
    function automatic logic [7:0] sel_to_an(input logic [2:0] sel);
        return ~(8'd1 << sel);
    endfunction

endpackage

// File: rtl/fnd_seg7_decoder.sv
// Combinational nibble-to-7-segment decoder (active-low {g..a}).
import fnd_pkg::*;

module seg7_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup; hex digits A-F use the usual mixed-case glyphs
    assign seg = GLYPH_TBL[nibble];

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed 7-segment display.
// Each digit dwells CLK_HZ/SCAN_HZ cycles: BLANK_CYC cycles with all anodes
// off (anti-ghosting dead time), then the digit is driven for the rest.
// All outputs are registered.
// Optional macro FND_DP_BLINK_EN: a 1 Hz toggle lights the decimal point on
// digits 2 and 4 while high (hh.mm.ss colon blink); otherwise dp stays off.
import fnd_pkg::*;

module fnd_scan_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 1_000,
    parameter int BLANK_CYC = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic [3:0] i_digit,
    output logic [2:0] o_sel,
    output logic [7:0] o_an,
    output logic [7:0] o_seg,
    output logic       o_frame_tick
);

    localparam int DWELL = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    // Counter values at which the blank and show phases end
    localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] LAST_SHOW  = CNT_W'(DWELL - 1);

    // The show phase needs at least two cycles (one to latch the glyph,
    // one to display it) and the blank phase at least one so anode
    // switching always happens with every anode off.
    generate
        if (BLANK_CYC < 1 || BLANK_CYC >= DWELL - 1) begin : g_bad_blank
            $error("fnd_scan_ctrl: BLANK_CYC must be in 1..DWELL-2");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_d;
    logic [7:0]       an_d;
    logic [7:0]       seg_d;
    logic             tick_d;
    logic [6:0]       glyph;
    logic             dp;

    seg7_decoder u_dec (
        .nibble (i_digit),
        .seg    (glyph)
    );

`ifdef FND_DP_BLINK_EN
    localparam int HALF_SEC = CLK_HZ / 2;
    localparam int HS_W     = (HALF_SEC > 1) ? $clog2(HALF_SEC) : 1;

    logic [HS_W-1:0] hs_cnt;
    logic            blink;

    // Free-running half-second divider; blink flips each half second
    // regardless of scan enable so the colon keeps a steady 1 Hz rhythm.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hs_cnt <= '0;
            blink  <= 1'b0;
        end else if (hs_cnt == HS_W'(HALF_SEC - 1)) begin
            hs_cnt <= '0;
            blink  <= ~blink;
        end else begin
            hs_cnt <= hs_cnt + 1'b1;
        end
    end

    // Colon dots sit after the hours and minutes digits
    assign dp = ~(blink && (o_sel == 3'd2 || o_sel == 3'd4));
`else
    assign dp = 1'b1;
`endif

    // State, counters and registered outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            o_sel        <= 3'd0;
            o_an         <= AN_OFF;
            o_seg        <= SEG_OFF;
            o_frame_tick <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            o_sel        <= sel_d;
            o_an         <= an_d;
            o_seg        <= seg_d;
            o_frame_tick <= tick_d;
        end
    end

    // Next-state and next-output logic. Anodes and segments default to dark
    // so every path that leaves SHOW turns the display off; o_an is only
    // ever loaded with a one-hot-zero pattern while entering or holding SHOW.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = o_sel;
        an_d    = AN_OFF;
        seg_d   = SEG_OFF;
        tick_d  = 1'b0;

        if (!i_en) begin
            // Disable wins from any state: go dark and rewind to digit 0
            state_d = IDLE;
            cnt_d   = '0;
            sel_d   = 3'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    sel_d   = 3'd0;
                end

                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BLANK) begin
                        // Anode turns on at the same edge the FSM enters SHOW.
                        // Segments stay dark this edge; the glyph of the new
                        // digit is latched during the first SHOW cycle.
                        state_d = SHOW;
                        an_d    = sel_to_an(o_sel);
                    end
                end

                SHOW: begin
                    if (cnt_q == LAST_SHOW) begin
                        // Last show cycle: blank, advance digit, restart dwell
                        state_d = BLANK;
                        cnt_d   = '0;
                        sel_d   = o_sel + 3'd1;
                        tick_d  = (o_sel == 3'd7);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        an_d  = sel_to_an(o_sel);
                        seg_d = {dp, glyph};
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sel_d   = 3'd0;
                end
            endcase
        end
    end

endmodule
